// File: rtl/module_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// module_bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3, "double dabble").
// Converts the binary product of two 2-digit operands into packed BCD digits
// for the 7-segment display path. One input bit is consumed per clock.
//
// Ports
//   clk      in   1          system clock
//   rst      in   1          asynchronous active-low reset
//   start    in   1          request a conversion of bin_in (honoured in IDLE only)
//   bin_in   in   BIN_W      binary value, captured on the accepting edge
//   busy     out  1          high while bits are being shifted (SHIFT state)
//   done     out  1          one-cycle pulse, bcd_out/ovf valid from this cycle
//   bcd_out  out  4*DIGITS   packed BCD, [3:0] = units ... top nibble = most significant
//   ovf      out  1          input exceeded 10^DIGITS-1, bcd_out saturated to all 9s
// ---------------------------------------------------------------------------
module module_bin2bcd_seq #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

   // Largest representable decimal value and largest possible input. When the
   // input range never reaches the decimal limit, clamp the threshold to the
   // input maximum so the overflow flag can never assert.
   localparam longint MAX_DEC = pow10(DIGITS) - 1;
   localparam longint BIN_MAX = (longint'(1) << BIN_W) - 1;
   localparam logic [BIN_W:0] MAX_CMP =
      (MAX_DEC > BIN_MAX) ? (BIN_W+1)'(BIN_MAX) : (BIN_W+1)'(MAX_DEC);

   localparam logic [BCD_W-1:0] SAT_VAL = {DIGITS{4'h9}};

   logic [1:0]        state;
   logic [BCD_W-1:0]  scratch;
   logic [BIN_W-1:0]  shreg;
   logic [CNT_W-1:0]  cnt;
   logic              ovf_pend;

   logic [BCD_W-1:0]  adj;
   logic [BCD_W-1:0]  scratch_nxt;
   logic [BIN_W-1:0]  shreg_nxt;

   // One double-dabble step: every digit >= 5 gets +3 in parallel, then the
   // combined {scratch, shreg} word shifts left by one. A digit is at most 9
   // before adjustment, so the +3 result fits in its own nibble.
   always_comb begin
      adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         end
      end
      scratch_nxt = {adj[BCD_W-2:0], shreg[BIN_W-1]};
      shreg_nxt   = {shreg[BIN_W-2:0], 1'b0};
   end

   // Control FSM and datapath. The result registers are loaded on the edge
   // that enters DONE (using the final shifted scratch value) so that bcd_out
   // and ovf are already valid during the cycle in which done is high, and
   // they stay untouched throughout SHIFT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         scratch  <= '0;
         shreg    <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         bcd_out  <= '0;
         ovf      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  shreg    <= bin_in;
                  scratch  <= '0;
                  cnt      <= CNT_W'(BIN_W);
                  ovf_pend <= ({1'b0, bin_in} > MAX_CMP);
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= scratch_nxt;
               shreg   <= shreg_nxt;
               cnt     <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state   <= DONE;
                  bcd_out <= ovf_pend ? SAT_VAL : scratch_nxt;
                  ovf     <= ovf_pend;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == SHIFT);
   assign done = (state == DONE);

endmodule
